// File: rtl/accum_seq.sv
// accum_seq: handshaked W-bit signed accumulator (ADD/SUB/LOAD/CLEAR) with a
// one-deep result buffer, overflow flags and an op counter. Optional SATURATE_EN.
module accum_seq #(
   parameter int W  = 8,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_op,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          out_ovf,
   output logic          ovf_sticky,
   output logic [CW-1:0] op_count
);

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic {EMPTY, FULL} state_t;

   state_t         state, state_nxt;
   logic           accept;
   logic [W-1:0]   acc;
   logic [W-1:0]   sum, diff, sat_val, acc_nxt;
   logic           add_ovf, sub_ovf, ovf_nxt;
   logic           clr;

   // Ready depends only on registered state and out_ready.
   always_comb begin
      state_nxt = state;
      in_ready  = (state == EMPTY) || out_ready;
      out_valid = (state == FULL);
      accept    = in_valid && in_ready;
      case (state)
         EMPTY: if (accept) state_nxt = FULL;
         FULL: begin
            if (accept)         state_nxt = FULL;
            else if (out_ready) state_nxt = EMPTY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   // Overflow direction always follows the accumulator's sign, so one
   // saturation value serves both ADD and SUB.
   always_comb begin
      sum     = acc + in_data;
      diff    = acc - in_data;
      add_ovf = (acc[W-1] == in_data[W-1]) && (sum[W-1]  != acc[W-1]);
      sub_ovf = (acc[W-1] != in_data[W-1]) && (diff[W-1] != acc[W-1]);
      sat_val = acc[W-1] ? SAT_MIN : SAT_MAX;
      clr     = 1'b0;
      ovf_nxt = 1'b0;
      acc_nxt = acc;
      case (in_op)
         OP_ADD: begin
            ovf_nxt = add_ovf;
`ifdef SATURATE_EN
            acc_nxt = add_ovf ? sat_val : sum;
`else
            acc_nxt = sum;
`endif
         end
         OP_SUB: begin
            ovf_nxt = sub_ovf;
`ifdef SATURATE_EN
            acc_nxt = sub_ovf ? sat_val : diff;
`else
            acc_nxt = diff;
`endif
         end
         OP_LOAD:  acc_nxt = in_data;
         OP_CLEAR: begin
            acc_nxt = '0;
            clr     = 1'b1;
         end
         default:  acc_nxt = acc;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         out_ovf    <= 1'b0;
         ovf_sticky <= 1'b0;
         op_count   <= '0;
      end else if (accept) begin
         acc     <= acc_nxt;
         out_ovf <= ovf_nxt;
         if (clr) begin
            ovf_sticky <= 1'b0;
            op_count   <= '0;
         end else begin
            ovf_sticky <= ovf_sticky | ovf_nxt;
            op_count   <= op_count + CW'(1);
         end
      end
   end

   assign out_data = acc;

endmodule

// File: tb/tb_accum_seq.sv
// Directed self-checking bench for accum_seq; expected values hand-computed,
// with SATURATE_EN-dependent expectations selected by the same macro.
module tb_accum_seq;

   logic       clk, rst;
   logic       in_valid, in_ready;
   logic [1:0] in_op;
   logic [7:0] in_data;
   logic       out_valid, out_ready;
   logic [7:0] out_data;
   logic       out_ovf, ovf_sticky;
   logic [7:0] op_count;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

   accum_seq #(.W(8), .CW(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .op_count(op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Present one command for exactly one edge; sample 1 time unit after it.
   task automatic send(input logic [1:0] op, input logic [7:0] d);
      in_valid = 1'b1; in_op = op; in_data = d;
      @(posedge clk); #1;
      in_valid = 1'b0; in_op = 2'b00; in_data = 8'h00;
   endtask

   initial begin
      logic [7:0] exp_v;
      logic       vld_ok;
      rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_data = 8'h00; out_ready = 1'b1;
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data, 0);
      check("rst_in_ready",  in_ready, 1);
      check("rst_op_count",  op_count, 0);
      check("rst_sticky",    {ovf_sticky, out_ovf}, 0);
      rst = 1'b0;

      send(ADD, 8'd5);
      check("add5_data", out_data, 8'd5);
      check("add5_valid", out_valid, 1);
      send(ADD, 8'd3);
      check("add3_data", out_data, 8'd8);
      check("add3_valid", out_valid, 1);
      send(SUB, 8'd10);
      check("sub10_data", out_data, 8'hFE);
      check("sub10_ovf", out_ovf, 0);
      check("sub10_cnt", op_count, 3);
      check("sub10_valid", out_valid, 1);

      send(LOAD, 8'h7F);
      check("load7f_ovf", out_ovf, 0);
      send(ADD, 8'h01);
`ifdef SATURATE_EN
      exp_v = 8'h7F;
`else
      exp_v = 8'h80;
`endif
      check("pos_ovf_data", out_data, exp_v);
      check("pos_ovf_flag", out_ovf, 1);
      check("pos_ovf_sticky", ovf_sticky, 1);

      send(LOAD, 8'h80);
      send(SUB, 8'h01);
`ifdef SATURATE_EN
      exp_v = 8'h80;
`else
      exp_v = 8'h7F;
`endif
      check("neg_ovf_data", out_data, exp_v);
      check("neg_ovf_flag", out_ovf, 1);
      send(ADD, 8'h00);
      check("add0_data", out_data, exp_v);
      check("add0_ovf", out_ovf, 0);
      check("add0_sticky", ovf_sticky, 1);
      check("add0_cnt", op_count, 8);
      send(CLR, 8'hAA);
      check("clr_data", out_data, 0);
      check("clr_sticky", ovf_sticky, 0);
      check("clr_cnt", op_count, 0);
      check("clr_ovf", out_ovf, 0);
      check("clr_valid", out_valid, 1);

      // Backpressure: result held, new command stalled until out_ready returns.
      send(ADD, 8'd4);
      check("bp_add4", out_data, 8'd4);
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = ADD; in_data = 8'd2;
      #1;
      check("bp_ready_comb", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("bp_hold_data", out_data, 8'd4);
         check("bp_hold_ready", in_ready, 0);
         check("bp_hold_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_add2_data", out_data, 8'd6);
      check("bp_add2_cnt", op_count, 2);
      @(posedge clk); #1;
      check("drain_valid", out_valid, 0);
      check("drain_data", out_data, 8'd6);
      in_valid = 1'b0; in_op = CLR; in_data = 8'hFF;
      @(posedge clk); #1;
      check("ignored_cnt", op_count, 2);

      // Counter wrap under continuous ADD 0.
      send(CLR, 8'h00);
      vld_ok = 1'b1;
      in_valid = 1'b1; in_op = ADD; in_data = 8'h00;
      for (int i = 1; i <= 256; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || in_ready !== 1'b1) vld_ok = 1'b0;
         if (i == 255) check("wrap_cnt255", op_count, 255);
      end
      in_valid = 1'b0;
      check("wrap_cnt0", op_count, 0);
      check("wrap_valid_all", vld_ok, 1);

      // Asynchronous reset while FULL with a pending result.
      send(LOAD, 8'h33);
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_data", out_data, 8'h33);
      check("pre_rst_valid", out_valid, 1);
      #3 rst = 1'b1;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_data", out_data, 0);
      check("async_rst_cnt", op_count, 0);
      #2 rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      send(ADD, 8'd1);
      check("post_rst_data", out_data, 8'd1);
      check("post_rst_cnt", op_count, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
